memory_access_controller: RTL and testbench
===========================================

Name: memory_access_controller

Overview:
Sequencer between the CPU control state machine and the memory unit. It accepts one load/store request at a time over a valid/ready handshake and inserts a programmable number of wait states. It then drives rw_flag/address/write_memory_value to memory for exactly one access cycle and returns the result over a valid/ready response channel. Out-of-range addresses are rejected without touching memory.

Parameters:
WAIT_CYCLES, 1, wait-state cycles inserted between request acceptance and the memory access cycle (0 allowed; max 15)
ADDR_LIMIT, `MEMSIZE, first illegal address; requests with address >= ADDR_LIMIT return an error

Ports:
CLOCK  input  1  system clock; all state changes on posedge
RESET  input  1  synchronous, active-high reset
req_valid  input  1  CPU presents a request
req_ready  output  1  controller can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_address  input  DEFAULT_TYPE  target address
req_data  input  DEFAULT_TYPE  store data
resp_valid  output  1  response available
resp_ready  input  1  CPU consumes response
resp_data  output  DEFAULT_TYPE  load data; 0 for stores and errors
resp_error  output  1  1 = address out of range
rw_flag  output  MEMORY_FLAG_TYPE  to memory; MEMORY_WRITE only in a store ACCESS cycle
address  output  DEFAULT_TYPE  to memory; latched request address
write_memory_value  output  DEFAULT_TYPE  to memory; latched store data
read_memory_value  input  DEFAULT_TYPE  from memory, combinational on address

Behaviour:
- States: IDLE, WAIT, ACCESS, DONE. Registered state, wait counter (4 bits), req_write/address/data latches, resp_data, and resp_error.
- Reset (RESET high at posedge): state=IDLE; latches, resp_data and resp_error all 0. Outputs after reset: req_ready=1, resp_valid=0, rw_flag=MEMORY_READ, address=0, write_memory_value=0. RESET has priority over every transition.
- req_ready = (state==IDLE). resp_valid = (state==DONE). Both are decoded from state only, with no combinational path from inputs.
- IDLE: when req_valid is high, latch req_write/req_address/req_data.
  - If req_address >= ADDR_LIMIT: go to DONE with resp_error=1, resp_data=0. No ACCESS cycle occurs.
  - Otherwise, if WAIT_CYCLES==0, go to ACCESS. Else go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: rw_flag=MEMORY_READ; address holds the latched value. If counter==0, go to ACCESS; else decrement the counter.
- ACCESS: lasts exactly one cycle.
  - rw_flag=MEMORY_WRITE if the latched write is 1, else MEMORY_READ.
  - Load: capture read_memory_value into resp_data. Store: resp_data=0.
  - resp_error=0; go to DONE.
- DONE: hold resp_data/resp_error stable while resp_valid=1 and resp_ready=0. On resp_ready=1, go to IDLE.
  - A new request is not accepted in the same cycle; the earliest acceptance is the next cycle.
- The address and write_memory_value outputs always equal the latches. They are stable for all WAIT, ACCESS and DONE cycles.
- Latency: request accepted at edge N -> ACCESS cycle at N+1+WAIT_CYCLES -> resp_valid high from N+2+WAIT_CYCLES. Error path: resp_valid high from N+1.
- req_valid is ignored outside IDLE. Request inputs need not be held after acceptance.
- Reset mid-operation, including in the ACCESS cycle: state returns to IDLE and no response is produced. Any write is governed by the memory's own reset priority.
- The MEMORY_WRITE flag never appears outside ACCESS. At most one memory write occurs per accepted store.

Test Plan:
- Reset, then idle 5 cycles -> req_ready=1, resp_valid=0, rw_flag=MEMORY_READ, address=0 every cycle.
- WAIT_CYCLES=1: store 0x5A to addr 3, then load addr 3 -> store resp_valid at accept+3 with resp_data=0 and resp_error=0; rw_flag=MEMORY_WRITE for exactly one cycle; load returns resp_data=0x5A.
- WAIT_CYCLES=0: load from a preloaded address -> resp_valid at accept+2 with the preloaded value.
- Load addr ADDR_LIMIT -> resp_valid at accept+1 with resp_error=1 and resp_data=0; rw_flag never MEMORY_WRITE; memory contents unchanged.
- Hold resp_ready=0 for 4 cycles in DONE while toggling req_valid -> resp_data stable, req_ready=0, no new acceptance. resp_ready=1 then returns to IDLE; a back-to-back request is accepted the following cycle.
- Assert RESET during the WAIT of a store -> next cycle is IDLE with resp_valid=0; the stored address is never written.

Source files
------------

// File: rtl/memory_access_controller_if.sv
// Request/response and memory-side bus of the memory access controller.
// The controller takes the slave view; the CPU/memory side takes the master view.
interface memory_access_controller_if #(
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [DW-1:0] req_address;
    logic [DW-1:0] req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_error;
    logic          rw_flag;
    logic [DW-1:0] address;
    logic [DW-1:0] write_memory_value;
    logic [DW-1:0] read_memory_value;

    modport slave (
        input  req_valid, req_write, req_address, req_data,
        input  resp_ready, read_memory_value,
        output req_ready, resp_valid, resp_data, resp_error,
        output rw_flag, address, write_memory_value
    );

    modport master (
        output req_valid, req_write, req_address, req_data,
        output resp_ready, read_memory_value,
        input  req_ready, resp_valid, resp_data, resp_error,
        input  rw_flag, address, write_memory_value
    );
endinterface

// File: rtl/memory_access_controller.sv
// Sequences one load/store at a time into a single memory access cycle,
// after a programmable number of wait states, with a held response.
`ifndef MEMSIZE
`define MEMSIZE 16
`endif

module memory_access_controller #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_LIMIT  = `MEMSIZE,
    parameter int DW          = 8
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    memory_access_controller_if.slave    bus
);
    localparam logic MEMORY_READ  = 1'b0;
    localparam logic MEMORY_WRITE = 1'b1;
    localparam bit   ZERO_WAIT    = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_INIT =
        ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [DW:0] LIMIT = (DW + 1)'(ADDR_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          out_of_range;

    assign out_of_range = {1'b0, bus.req_address} >= LIMIT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_d   = bus.req_write;
                    addr_d = bus.req_address;
                    data_d = bus.req_data;
                    if (out_of_range) begin
                        // rejected without ever reaching memory
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end else if (ZERO_WAIT) begin
                        state_d = ACCESS;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ACCESS: begin
                rdata_d = wr_q ? '0 : bus.read_memory_value;
                err_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready          = (state_q == IDLE);
    assign bus.resp_valid         = (state_q == DONE);
    assign bus.resp_data          = rdata_q;
    assign bus.resp_error         = err_q;
    assign bus.address            = addr_q;
    assign bus.write_memory_value = data_q;
    assign bus.rw_flag            = (state_q == ACCESS && wr_q) ?
                                    MEMORY_WRITE : MEMORY_READ;
endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller: two instances (1 and 0 wait states)
// against a transaction-level reference of latency, response and memory.
module tb_memory_access_controller;
    localparam int DW    = 8;
    localparam int LIMIT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    bit   sel = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] mem1 [16];
    logic [7:0] mem0 [16];
    logic [7:0] ref1 [16];
    logic [7:0] ref0 [16];

    memory_access_controller_if #(.DW(DW)) if1 ();
    memory_access_controller_if #(.DW(DW)) if0 ();

    memory_access_controller #(.WAIT_CYCLES(1), .ADDR_LIMIT(LIMIT), .DW(DW))
        dut1 (.CLOCK(clk), .RESET(rst), .bus(if1));
    memory_access_controller #(.WAIT_CYCLES(0), .ADDR_LIMIT(LIMIT), .DW(DW))
        dut0 (.CLOCK(clk), .RESET(rst), .bus(if0));

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 7 + 1);
    endfunction

    assign if1.read_memory_value = (if1.address < 8'd16) ? mem1[if1.address[3:0]] : 8'h00;
    assign if0.read_memory_value = (if0.address < 8'd16) ? mem0[if0.address[3:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= init_val(i);
                mem0[i] <= init_val(i);
            end
        end else if (!rst) begin
            if (if1.rw_flag && if1.address < 8'd16)
                mem1[if1.address[3:0]] <= if1.write_memory_value;
            if (if0.rw_flag && if0.address < 8'd16)
                mem0[if0.address[3:0]] <= if0.write_memory_value;
        end
    end

    logic       o_req_ready, o_resp_valid, o_resp_error, o_rw_flag;
    logic [7:0] o_resp_data, o_address, o_wdata;

    always_comb begin
        o_req_ready  = if0.req_ready;
        o_resp_valid = if0.resp_valid;
        o_resp_error = if0.resp_error;
        o_rw_flag    = if0.rw_flag;
        o_resp_data  = if0.resp_data;
        o_address    = if0.address;
        o_wdata      = if0.write_memory_value;
        if (sel) begin
            o_req_ready  = if1.req_ready;
            o_resp_valid = if1.resp_valid;
            o_resp_error = if1.resp_error;
            o_rw_flag    = if1.rw_flag;
            o_resp_data  = if1.resp_data;
            o_address    = if1.address;
            o_wdata      = if1.write_memory_value;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input bit v, input bit w, input logic [7:0] a, input logic [7:0] d);
        if1.req_valid   = sel & v;
        if0.req_valid   = !sel & v;
        if1.req_write   = w;
        if0.req_write   = w;
        if1.req_address = a;
        if0.req_address = a;
        if1.req_data    = d;
        if0.req_data    = d;
    endtask

    task automatic set_rr(input bit r);
        if1.resp_ready = sel & r;
        if0.resp_ready = !sel & r;
    endtask

    // Entered and left at a negedge; issues one request and retires it.
    task automatic txn(input bit s, input bit w, input logic [7:0] a,
                       input logic [7:0] d, input int hold);
        bit         err;
        int         lat;
        int         wcnt;
        logic [7:0] exp_data;
        sel  = s;
        err  = (int'(a) >= LIMIT);
        lat  = err ? 1 : (s ? 1 : 0) + 2;
        wcnt = 0;
        if (err || w) exp_data = 8'h00;
        else          exp_data = s ? ref1[a[3:0]] : ref0[a[3:0]];
        if (!err && w) begin
            if (s) ref1[a[3:0]] = d;
            else   ref0[a[3:0]] = d;
        end
        #1;
        chk("req_ready_idle", o_req_ready, 1);
        drive_req(1'b1, w, a, d);
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (o_rw_flag) wcnt++;
            chk("addr_latched", o_address, a);
            chk("resp_valid_timing", o_resp_valid, (k == lat));
            if (k < lat) chk("req_ready_busy", o_req_ready, 0);
        end
        if (w) chk("wdata_latched", o_wdata, d);
        chk("resp_data", o_resp_data, exp_data);
        chk("resp_error", o_resp_error, err);
        chk("write_count", wcnt, (w && !err) ? 1 : 0);
        for (int h = 0; h < hold; h++) begin
            drive_req(1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
            @(negedge clk);
            chk("hold_valid", o_resp_valid, 1);
            chk("hold_ready", o_req_ready, 0);
            chk("hold_data", o_resp_data, exp_data);
            chk("hold_rw", o_rw_flag, 0);
        end
        drive_req(1'b0, 1'b0, 8'h00, 8'h00);
        set_rr(1'b1);
        @(negedge clk);
        chk("resp_consumed", o_resp_valid, 0);
        chk("back_to_idle", o_req_ready, 1);
        set_rr(1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref1[i] = init_val(i);
            ref0[i] = init_val(i);
        end
        drive_req(1'b0, 1'b0, 8'h00, 8'h00);
        set_rr(1'b0);
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_req_ready", o_req_ready, 1);
            chk("rst_resp_valid", o_resp_valid, 0);
            chk("rst_rw_flag", o_rw_flag, 0);
            chk("rst_address", o_address, 0);
        end
        chk("rst_w0_ready", if0.req_ready, 1);
        chk("rst_w0_valid", if0.resp_valid, 0);

        txn(1'b1, 1'b1, 8'd3, 8'h5A, 0);
        txn(1'b1, 1'b0, 8'd3, 8'h00, 0);
        txn(1'b0, 1'b0, 8'd9, 8'h00, 0);
        txn(1'b1, 1'b0, 8'd16, 8'h00, 0);
        txn(1'b1, 1'b1, 8'd16, 8'h77, 0);
        txn(1'b0, 1'b1, 8'd20, 8'h66, 1);
        txn(1'b1, 1'b0, 8'd5, 8'h00, 4);
        txn(1'b1, 1'b1, 8'd7, 8'h33, 0);
        txn(1'b0, 1'b1, 8'd2, 8'hC4, 2);
        txn(1'b0, 1'b0, 8'd2, 8'h00, 0);

        // Reset lands while a store waits; the store must never reach memory.
        sel = 1'b1;
        #1;
        drive_req(1'b1, 1'b1, 8'd5, 8'hEE);
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("wait_rw_read", o_rw_flag, 0);
        chk("wait_busy", o_req_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", o_req_ready, 1);
        chk("midrst_valid", o_resp_valid, 0);
        chk("midrst_addr", o_address, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_rw", o_rw_flag, 0);
            chk("midrst_no_resp", o_resp_valid, 0);
        end
        chk("midrst_mem", mem1[5], ref1[5]);

        for (int t = 0; t < 24; t++) begin
            txn(1'($urandom), 1'($urandom), 8'($urandom_range(0, 19)),
                8'($urandom), int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            chk("mem1_final", mem1[i], ref1[i]);
            chk("mem0_final", mem0[i], ref0[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
